fetch_decode: RTL

- Upstream neighbour of the ALU stage: owns the program counter, fetches 32-bit RV32I instructions from the firmware instruction memory over a req/valid handshake, and decodes them into the fields the ALU consumes (opcode, func3, func7, imm, register addresses, pc_current_address).
- Takes pc_next_address back from the ALU each instruction.
- Outputs are registered and held stable for the whole execute slot.

---
 rtl/fetch_decode.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch and RV32I decode stage: owns the PC, fetches over a req/valid
// handshake and presents registered decoded fields for one execute slot per instruction.
module fetch_decode #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FW_LENGTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] pc_next_address,
  output logic [DATA_WIDTH-1:0] pc_current_address,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  output logic [4:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  instr_valid,
  output logic                  illegal_instr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [DATA_WIDTH-1:0] FW_VOLUME = DATA_WIDTH'(FW_LENGTH) << 2;

  // Word-align the ALU's next PC and wrap anything past the end of firmware to 0.
  function automatic logic [DATA_WIDTH-1:0] sanitise_pc(input logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH-1:0] aligned;
    aligned = {pc[DATA_WIDTH-1:2], 2'b00};
    return (aligned >= FW_VOLUME) ? '0 : aligned;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  accept;

  logic [6:0]            opcode_q, opcode_d;
  logic [2:0]            func3_q, func3_d;
  logic [6:0]            func7_q, func7_d;
  logic [4:0]            rs1_q, rs1_d;
  logic [4:0]            rs2_q, rs2_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  illegal_q, illegal_d;

  logic [6:0]            raw_op;
  logic [2:0]            raw_f3;
  logic [6:0]            raw_f7;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic                  legal;

  assign raw_op = imem_rdata[6:0];
  assign raw_f3 = imem_rdata[14:12];
  assign raw_f7 = imem_rdata[31:25];

  assign imm_i = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign imm_j = {{(DATA_WIDTH-21){imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign imm_u = {{(DATA_WIDTH-20){1'b0}}, imem_rdata[31:12]};

  // Decode of the word currently on the bus; captured only when a fetch completes.
  always_comb begin
    legal     = 1'b1;
    func3_d   = '0;
    func7_d   = '0;
    imm_d     = '0;
    opcode_d  = '0;
    rd_d      = '0;
    rs1_d     = '0;
    rs2_d     = '0;
    case (raw_op)
      OP_R: begin
        func3_d = raw_f3;
        func7_d = raw_f7;
      end
      OP_IMM: begin
        func3_d = raw_f3;
        if (raw_f3 == 3'b001 || raw_f3 == 3'b101) func7_d = raw_f7;
        imm_d   = imm_i;
      end
      OP_LOAD, OP_JALR: begin
        func3_d = raw_f3;
        imm_d   = imm_i;
      end
      OP_STORE: begin
        func3_d = raw_f3;
        imm_d   = imm_s;
      end
      OP_BRANCH: begin
        func3_d = raw_f3;
        imm_d   = imm_b;
      end
      OP_LUI, OP_AUIPC: imm_d = imm_u;
      OP_JAL:           imm_d = imm_j;
      default:          legal = 1'b0;
    endcase
    if (legal) begin
      opcode_d = raw_op;
      rd_d     = imem_rdata[11:7];
      rs1_d    = imem_rdata[19:15];
      rs2_d    = imem_rdata[24:20];
    end
    illegal_d = ~legal;
  end

  assign accept = (state_q == ST_FETCH) && imem_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!stall) begin
          state_d = ST_FETCH;
          pc_d    = sanitise_pc(pc_next_address);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      func3_q   <= '0;
      func7_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (accept) begin
        opcode_q  <= opcode_d;
        func3_q   <= func3_d;
        func7_q   <= func7_d;
        rs1_q     <= rs1_d;
        rs2_q     <= rs2_d;
        rd_q      <= rd_d;
        imm_q     <= imm_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign imem_req           = (state_q == ST_FETCH);
  assign imem_addr          = pc_q;
  assign pc_current_address = pc_q;
  assign instr_valid        = (state_q == ST_EXEC);
  assign opcode             = opcode_q;
  assign func3              = func3_q;
  assign func7              = func7_q;
  assign rs1_addr           = rs1_q;
  assign rs2_addr           = rs2_q;
  assign rd_addr            = rd_q;
  assign imm                = imm_q;
  assign illegal_instr      = illegal_q;

endmodule
